mmio_bridge: RTL and testbench
==============================

Name: mmio_bridge

Overview:
- Next-generation CPU-to-memory/peripheral bridge for the miniRV SoC.
- Decodes each CPU access to DRAM or to a memory-mapped I/O page and owns the peripheral registers: LEDs, switches, buttons, 8-digit seven-segment display and a free-running timer.
- Sits between the CPU core and DRAM/board I/O.
- Replaces the DRAM-only bridge, which had no peripheral state and an undriven read path for non-DRAM addresses.

Parameters:
- MMIO_PAGE, 20'hFFFFF: addr[31:12] value selecting the I/O page; every other value selects DRAM.
- LED_W, 24: LED register width.
- SW_W, 24: switch input width.
- BTN_W, 5: button input width.
- SCAN_DIV, 20000: clock cycles per display digit (scan period).
- TIMER_W, 32: timer counter width.

Ports:
- clk_from_cpu  in  1  system clock; all state updates on rising edge.
- rst_from_cpu  in  1  reset, asynchronous, active-low.
- addr_from_cpu  in  32  byte address.
- we_from_cpu  in  1  write enable for the current access.
- wdata_from_cpu  in  32  write data.
- rdata_to_cpu  out  32  read data (combinational).
- clk_to_dram  out  1  equals clk_from_cpu.
- addr_to_dram  out  32  equals addr_from_cpu.
- we_to_dram  out  1  we_from_cpu gated by DRAM select.
- wdata_to_dram  out  32  equals wdata_from_cpu.
- rdata_from_dram  in  32  DRAM read data.
- sw  in  SW_W  raw switches (asynchronous).
- btn  in  BTN_W  raw buttons (asynchronous).
- led  out  LED_W  LED register.
- dig_en  out  8  digit enables, active-low, one-hot-low.
- dig_seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Behaviour:
- Decode: sel_io = (addr[31:12]==MMIO_PAGE); sel_dram = !sel_io.
- Register offsets are addr[11:0]. Valid offsets: 0x000 DIG, 0x020 TIMER, 0x024 TDIV, 0x060 LED, 0x070 SW, 0x078 BTN. Any other offset in the page is unmapped.
- Writes happen on the clock edge when we_from_cpu && sel_io && offset matches. DIG, TIMER, TDIV and LED are writable. Writes to SW, BTN or unmapped offsets are dropped.
- Reads, combinational:
  - DRAM selected: rdata_from_dram.
  - Mapped register: the register value, zero-extended to 32 bits.
  - Unmapped offset: 32'h0.
  - No latch allowed; every path drives rdata_to_cpu.
- Reset values (rst_from_cpu low, immediate and asynchronous):
  - led=0, DIG=0, TIMER=0, TDIV=0, prescale counter=0, scan counter=0, digit index=0.
  - sw/btn synchronizers=0.
  - dig_en=8'hFF (all off), dig_seg=8'hFF.
- Reset asserted mid-access: the write is lost and state returns to reset values. The first write after deassertion is honoured.
- SW/BTN:
  - Two-flop synchronizer per bit; reads return the second flop, so latency is 2 clocks from a pin change.
  - No debouncing; that is software's job.
- Timer:
  - 32-bit prescale counter counts 0..TDIV and wraps to 0.
  - On wrap, TIMER increments, wrapping modulo 2^TIMER_W.
  - TDIV=0 means TIMER increments every cycle.
  - A CPU write to TIMER on the same edge as an increment: the write wins, and the prescale counter is not reset.
  - A write to TDIV resets the prescale counter to 0 on the same edge.
- Display scan:
  - Scan counter counts 0..SCAN_DIV-1; at terminal count the digit index advances 0→7 and wraps to 0.
  - dig_en = ~(8'b1 << idx).
  - dig_seg = hex-to-7seg of DIG[4*idx+3:4*idx] (0-F), dp off.
  - Outputs are registered: they update one clock after the index changes.
  - A DIG write is visible on the next displayed digit without restarting the scan.
- DRAM path: we_to_dram = we_from_cpu & sel_dram. An I/O write must never assert we_to_dram.

Decomposition:
- Shared package/defines: MMIO_PAGE default and the register offset constants (OFF_DIG, OFF_TIMER, OFF_TDIV, OFF_LED, OFF_SW, OFF_BTN).
- One sub-module, seg_scan: scan counter, digit index, hex decoder and registered dig_en/dig_seg. Its inputs are the clock, reset, the 32-bit DIG value and SCAN_DIV.
- Timer, registers and decode stay in mmio_bridge.

Test Plan:
- DRAM access: addr=0x0000_1000, we=1, wdata=0xDEADBEEF → we_to_dram=1, led unchanged. Read of the same address returns rdata_from_dram. Write to 0xFFFF_F060 → we_to_dram=0.
- LED/SW: write 0x00A5A5A5 to 0xFFFF_F060 → led=24'hA5A5A5 next edge. Drive sw=24'h123456 → read 0xFFFF_F070 returns 0x00123456 from the 2nd clock on, not the 1st. Read 0xFFFF_F100 → 0x0.
- Timer: write TDIV=3 then TIMER=0 → TIMER reads 1 after 4 clocks and 5 after 20. Write TIMER=0xFFFF_FFFF with TDIV=0 → next cycle reads 0x0. Write coinciding with an increment → written value holds.
- Display: SCAN_DIV=4, DIG=0x0000_00A1 → after reset dig_en=FF. First scanned digit: dig_en=FE, dig_seg=F9 ("1"). Next digit: dig_en=FD, dig_seg=88 ("A"). Digit 7 wraps back to FE.
- Async reset: assert rst_from_cpu low mid-cycle with led=0xFFFFFF and TIMER running → led=0, dig_en=FF immediately without waiting for a clock edge. Counting resumes from 0 after release.

Source files
------------

// File: rtl/mmio_bridge_pkg.sv
// Shared constants and helpers for the miniRV MMIO bridge: I/O page, register
// offsets, offset decoder and the hex-to-seven-segment table.
package mmio_bridge_pkg;

    localparam logic [19:0] MMIO_PAGE_DEFAULT = 20'hFFFFF;

    localparam logic [11:0] OFF_DIG   = 12'h000;
    localparam logic [11:0] OFF_TIMER = 12'h020;
    localparam logic [11:0] OFF_TDIV  = 12'h024;
    localparam logic [11:0] OFF_LED   = 12'h060;
    localparam logic [11:0] OFF_SW    = 12'h070;
    localparam logic [11:0] OFF_BTN   = 12'h078;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_DIG,
        REG_TIMER,
        REG_TDIV,
        REG_LED,
        REG_SW,
        REG_BTN
    } reg_sel_e;

    function automatic reg_sel_e decode_offset(input logic [11:0] off);
        reg_sel_e sel;
        case (off)
            OFF_DIG:   sel = REG_DIG;
            OFF_TIMER: sel = REG_TIMER;
            OFF_TDIV:  sel = REG_TDIV;
            OFF_LED:   sel = REG_LED;
            OFF_SW:    sel = REG_SW;
            OFF_BTN:   sel = REG_BTN;
            default:   sel = REG_NONE;
        endcase
        return sel;
    endfunction

    // Active-low segments {dp,g,f,e,d,c,b,a}, decimal point always off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/mmio_bridge_seg_scan.sv
// Eight-digit multiplexed seven-segment scanner; outputs are registered one
// clock behind the digit index.
module seg_scan
    import mmio_bridge_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dig,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] scan_cnt;
    logic [2:0]       idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == CNT_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    // DIG is sampled live, so a CPU write shows up on the next digit shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_en  <= '1;
            dig_seg <= '1;
        end else begin
            dig_en  <= ~(8'b1 << idx);
            dig_seg <= hex_to_seg(dig[4*idx +: 4]);
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// CPU-side bridge: routes accesses to DRAM or the I/O page and owns the LED,
// switch, button, display and timer registers.
module mmio_bridge
    import mmio_bridge_pkg::*;
#(
    parameter logic [19:0] MMIO_PAGE = MMIO_PAGE_DEFAULT,
    parameter int unsigned LED_W     = 24,
    parameter int unsigned SW_W      = 24,
    parameter int unsigned BTN_W     = 5,
    parameter int unsigned SCAN_DIV  = 20000,
    parameter int unsigned TIMER_W   = 32
) (
    input  logic              clk_from_cpu,
    input  logic              rst_from_cpu,
    input  logic [31:0]       addr_from_cpu,
    input  logic              we_from_cpu,
    input  logic [31:0]       wdata_from_cpu,
    output logic [31:0]       rdata_to_cpu,
    output logic              clk_to_dram,
    output logic [31:0]       addr_to_dram,
    output logic              we_to_dram,
    output logic [31:0]       wdata_to_dram,
    input  logic [31:0]       rdata_from_dram,
    input  logic [SW_W-1:0]   sw,
    input  logic [BTN_W-1:0]  btn,
    output logic [LED_W-1:0]  led,
    output logic [7:0]        dig_en,
    output logic [7:0]        dig_seg
);

    logic                sel_io;
    logic                sel_dram;
    reg_sel_e            reg_sel;
    logic                wr_dig, wr_timer, wr_tdiv, wr_led;

    logic [31:0]         dig;
    logic [31:0]         tdiv;
    logic [31:0]         prescale;
    logic [TIMER_W-1:0]  timer;
    logic [SW_W-1:0]     sw_meta, sw_sync;
    logic [BTN_W-1:0]    btn_meta, btn_sync;
    logic                tick;

    assign sel_io   = (addr_from_cpu[31:12] == MMIO_PAGE);
    assign sel_dram = !sel_io;
    assign reg_sel  = decode_offset(addr_from_cpu[11:0]);

    assign wr_dig   = we_from_cpu && sel_io && (reg_sel == REG_DIG);
    assign wr_timer = we_from_cpu && sel_io && (reg_sel == REG_TIMER);
    assign wr_tdiv  = we_from_cpu && sel_io && (reg_sel == REG_TDIV);
    assign wr_led   = we_from_cpu && sel_io && (reg_sel == REG_LED);

    assign clk_to_dram   = clk_from_cpu;
    assign addr_to_dram  = addr_from_cpu;
    assign wdata_to_dram = wdata_from_cpu;
    assign we_to_dram    = we_from_cpu & sel_dram;

    always_ff @(posedge clk_from_cpu or negedge rst_from_cpu) begin
        if (!rst_from_cpu) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            btn_meta <= btn;
            btn_sync <= btn_meta;
        end
    end

    always_ff @(posedge clk_from_cpu or negedge rst_from_cpu) begin
        if (!rst_from_cpu) begin
            led  <= '0;
            dig  <= '0;
            tdiv <= '0;
        end else begin
            if (wr_led)  led  <= LED_W'(wdata_from_cpu);
            if (wr_dig)  dig  <= wdata_from_cpu;
            if (wr_tdiv) tdiv <= wdata_from_cpu;
        end
    end

    assign tick = (prescale == tdiv);

    // A TIMER write overrides that edge's increment but leaves the prescaler running.
    always_ff @(posedge clk_from_cpu or negedge rst_from_cpu) begin
        if (!rst_from_cpu) begin
            prescale <= '0;
            timer    <= '0;
        end else begin
            if (wr_tdiv || tick) prescale <= '0;
            else                 prescale <= prescale + 32'd1;

            if (wr_timer)  timer <= TIMER_W'(wdata_from_cpu);
            else if (tick) timer <= timer + TIMER_W'(1);
        end
    end

    always_comb begin
        rdata_to_cpu = '0;
        if (sel_dram) begin
            rdata_to_cpu = rdata_from_dram;
        end else begin
            case (reg_sel)
                REG_DIG:   rdata_to_cpu = dig;
                REG_TIMER: rdata_to_cpu = 32'(timer);
                REG_TDIV:  rdata_to_cpu = tdiv;
                REG_LED:   rdata_to_cpu = 32'(led);
                REG_SW:    rdata_to_cpu = 32'(sw_sync);
                REG_BTN:   rdata_to_cpu = 32'(btn_sync);
                default:   rdata_to_cpu = '0;
            endcase
        end
    end

    seg_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .clk     (clk_from_cpu),
        .rst_n   (rst_from_cpu),
        .dig     (dig),
        .dig_en  (dig_en),
        .dig_seg (dig_seg)
    );

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed self-checking bench for mmio_bridge with a shortened scan period.
module tb_mmio_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        clk_dram;
    logic [31:0] addr_dram;
    logic        we_dram;
    logic [31:0] wdata_dram;
    logic [31:0] rdata_dram;
    logic [23:0] sw;
    logic [4:0]  btn;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  dig_seg;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mmio_bridge #(
        .SCAN_DIV (4)
    ) dut (
        .clk_from_cpu    (clk),
        .rst_from_cpu    (rst_n),
        .addr_from_cpu   (addr),
        .we_from_cpu     (we),
        .wdata_from_cpu  (wdata),
        .rdata_to_cpu    (rdata),
        .clk_to_dram     (clk_dram),
        .addr_to_dram    (addr_dram),
        .we_to_dram      (we_dram),
        .wdata_to_dram   (wdata_dram),
        .rdata_from_dram (rdata_dram),
        .sw              (sw),
        .btn             (btn),
        .led             (led),
        .dig_en          (dig_en),
        .dig_seg         (dig_seg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d);
        addr  = a;
        we    = w;
        wdata = d;
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        addr       = 32'h0;
        we         = 1'b0;
        wdata      = 32'h0;
        rdata_dram = 32'hCAFE_F00D;
        sw         = '0;
        btn        = '0;

        // Reset state
        #10;
        drive(32'hFFFF_F020, 1'b0, 32'h0);
        check("rst_led", 32'(led), 32'h0);
        check("rst_dig_en", 32'(dig_en), 32'hFF);
        check("rst_dig_seg", 32'(dig_seg), 32'hFF);
        check("rst_timer", rdata, 32'h0);

        // Release between edges, write DIG=0xA1 on the first edge
        rst_n = 1'b1;
        drive(32'hFFFF_F000, 1'b1, 32'h0000_00A1);
        check("rel_dig_en", 32'(dig_en), 32'hFF);
        step(1);
        check("e1_dig_en", 32'(dig_en), 32'hFE);
        check("e1_dig_seg_old", 32'(dig_seg), 32'hC0);
        drive(32'hFFFF_F000, 1'b0, 32'h0);
        check("dig_read", rdata, 32'h0000_00A1);
        step(1);
        check("d0_en", 32'(dig_en), 32'hFE);
        check("d0_seg", 32'(dig_seg), 32'hF9);
        step(2);
        check("d0_hold_en", 32'(dig_en), 32'hFE);
        step(1);
        check("d1_en", 32'(dig_en), 32'hFD);
        check("d1_seg", 32'(dig_seg), 32'h88);
        step(4);
        check("d2_en", 32'(dig_en), 32'hFB);
        check("d2_seg", 32'(dig_seg), 32'hC0);
        step(20);
        check("d7_en", 32'(dig_en), 32'h7F);
        step(4);
        check("wrap_en", 32'(dig_en), 32'hFE);
        check("wrap_seg", 32'(dig_seg), 32'hF9);

        // DRAM path
        drive(32'h0000_1000, 1'b1, 32'hDEAD_BEEF);
        check("dram_we", 32'(we_dram), 32'h1);
        check("dram_wdata", wdata_dram, 32'hDEAD_BEEF);
        check("dram_addr", addr_dram, 32'h0000_1000);
        check("dram_rdata", rdata, 32'hCAFE_F00D);
        step(1);
        check("dram_led_unchanged", 32'(led), 32'h0);

        // LED write through the I/O page
        drive(32'hFFFF_F060, 1'b1, 32'h00A5_A5A5);
        check("io_no_dram_we", 32'(we_dram), 32'h0);
        step(1);
        check("led_write", 32'(led), 32'h00A5_A5A5);
        drive(32'hFFFF_F060, 1'b0, 32'h0);
        check("led_read", rdata, 32'h00A5_A5A5);

        // Dropped writes and unmapped reads
        drive(32'hFFFF_F100, 1'b1, 32'h1234_5678);
        step(1);
        check("unmapped_wr_led", 32'(led), 32'h00A5_A5A5);
        drive(32'hFFFF_F100, 1'b0, 32'h0);
        check("unmapped_read", rdata, 32'h0);
        drive(32'hFFFF_F070, 1'b1, 32'hFFFF_FFFF);
        step(1);
        drive(32'hFFFF_F070, 1'b0, 32'h0);
        check("sw_wr_dropped", rdata, 32'h0);

        // Switch/button synchronizer latency
        sw  = 24'h123456;
        btn = 5'h15;
        step(1);
        check("sw_1clk", rdata, 32'h0);
        step(1);
        check("sw_2clk", rdata, 32'h0012_3456);
        drive(32'hFFFF_F078, 1'b0, 32'h0);
        check("btn_2clk", rdata, 32'h0000_0015);

        // Prescaled timer
        drive(32'hFFFF_F024, 1'b1, 32'h3);
        step(1);
        drive(32'hFFFF_F020, 1'b1, 32'h0);
        step(1);
        drive(32'hFFFF_F020, 1'b0, 32'h0);
        check("tmr_after_wr", rdata, 32'h0);
        step(2);
        check("tmr_3clk", rdata, 32'h0);
        step(1);
        check("tmr_4clk", rdata, 32'h1);
        step(16);
        check("tmr_20clk", rdata, 32'h5);
        drive(32'hFFFF_F024, 1'b0, 32'h0);
        check("tdiv_read", rdata, 32'h3);

        // TDIV=0, wrap at 2^32, write beating an increment
        drive(32'hFFFF_F024, 1'b1, 32'h0);
        step(1);
        drive(32'hFFFF_F020, 1'b1, 32'hFFFF_FFFF);
        step(1);
        drive(32'hFFFF_F020, 1'b0, 32'h0);
        check("tmr_max", rdata, 32'hFFFF_FFFF);
        step(1);
        check("tmr_wrap", rdata, 32'h0);
        drive(32'hFFFF_F020, 1'b1, 32'h0000_0100);
        step(1);
        drive(32'hFFFF_F020, 1'b0, 32'h0);
        check("tmr_wr_wins", rdata, 32'h0000_0100);
        step(1);
        check("tmr_after_win", rdata, 32'h0000_0101);

        // Asynchronous reset mid-cycle
        drive(32'hFFFF_F060, 1'b1, 32'h00FF_FFFF);
        step(1);
        check("led_full", 32'(led), 32'h00FF_FFFF);
        drive(32'hFFFF_F060, 1'b1, 32'h0000_0123);
        rst_n = 1'b0;
        #1;
        check("arst_led", 32'(led), 32'h0);
        check("arst_dig_en", 32'(dig_en), 32'hFF);
        check("arst_dig_seg", 32'(dig_seg), 32'hFF);
        step(1);
        check("arst_wr_lost", 32'(led), 32'h0);
        rst_n = 1'b1;
        #1;
        step(1);
        check("post_rst_wr", 32'(led), 32'h0000_0123);
        drive(32'hFFFF_F020, 1'b0, 32'h0);
        check("post_rst_tmr1", rdata, 32'h1);
        step(1);
        check("post_rst_tmr2", rdata, 32'h2);
        drive(32'hFFFF_F070, 1'b0, 32'h0);
        check("post_rst_sw", rdata, 32'h0012_3456);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
